// File: rtl/fp_mul_pkg.sv
// Shared definitions for the pipelined floating-point multiplier family:
// word/bias helpers, rounding-mode codes and the per-stage tag payload.
package fp_mul_pkg;

  localparam int RND_TRUNC = 0;
  localparam int RND_RNE   = 1;

  function automatic int calc_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int calc_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  typedef struct packed {
    logic sign;
    logic exc;
    logic zero;
  } fp_tag_t;

endpackage

// File: rtl/fp_mul_norm_round.sv
// Combinational normalise / round / saturate / pack for a raw significand product.
// Shared with the fused multiply-add datapath.
module fp_mul_norm_round
  import fp_mul_pkg::*;
#(
  parameter int  EXP_W      = 8,
  parameter int  MAN_W      = 23,
  parameter int  ROUND_MODE = RND_TRUNC,
  localparam int W          = calc_w(EXP_W, MAN_W),
  localparam int EW2        = EXP_W + 2,
  localparam int PW         = 2 * MAN_W + 2
) (
  input  logic                  sign,
  input  logic                  exc,
  input  logic                  zero,
  input  logic signed [EW2-1:0] esum,
  input  logic [PW-1:0]         prod,
  output logic [W-1:0]          result,
  output logic                  exception,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] E_ZERO = '0;

  function automatic logic rne_inc(input logic guard, input logic sticky, input logic lsb);
    return (ROUND_MODE == RND_RNE) && guard && (sticky || lsb);
  endfunction

  function automatic logic [W-1:0] saturate(input logic s, input logic to_inf, input logic to_zero,
                                            input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (to_inf)  return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    if (to_zero) return {s, {(W-1){1'b0}}};
    return {s, e, m};
  endfunction

  logic [PW-2:0]         aligned;
  logic [MAN_W:0]        man_r;
  logic                  guard;
  logic                  sticky;
  logic                  ovf;
  logic                  unf;
  logic signed [EW2-1:0] e;

  always_comb begin
    // Drop the leading one; a product below 2.0 needs one extra left shift.
    aligned   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    guard     = aligned[MAN_W];
    sticky    = |aligned[MAN_W-1:0];
    man_r     = {1'b0, aligned[PW-2 -: MAN_W]}
              + (MAN_W+1)'(rne_inc(guard, sticky, aligned[MAN_W+1]));
    // A carry out of rounding leaves the stored mantissa at zero and bumps the exponent.
    e         = esum + (prod[PW-1] ? E_ONE : E_ZERO) + (man_r[MAN_W] ? E_ONE : E_ZERO);
    ovf       = !zero && (e >= E_MAX);
    unf       = !zero && (e <= E_ZERO);
    result    = saturate(sign, exc || ovf, zero || unf, e[EXP_W-1:0], man_r[MAN_W-1:0]);
    exception = exc;
    overflow  = ovf && !exc;
    underflow = unf && !exc;
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier (decode, multiply, normalise/round/pack)
// with bubble-collapsing valid/ready flow control and full backpressure.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int  EXP_W      = 8,
  parameter int  MAN_W      = 23,
  parameter int  ROUND_MODE = RND_TRUNC,
  localparam int W          = calc_w(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_operand,
  input  logic [W-1:0] b_operand,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         exception,
  output logic         overflow,
  output logic         underflow
);

  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = calc_bias(EXP_W);
  localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);

  typedef struct packed {
    fp_tag_t               tag;
    logic signed [EW2-1:0] esum;
    logic [MAN_W:0]        sig_a;
    logic [MAN_W:0]        sig_b;
  } s1_t;

  typedef struct packed {
    fp_tag_t               tag;
    logic signed [EW2-1:0] esum;
    logic [PW-1:0]         prod;
  } s2_t;

  typedef struct packed {
    logic [W-1:0] result;
    logic         exception;
    logic         overflow;
    logic         underflow;
  } s3_t;

  logic vld_p1_d, vld_p1_q;
  logic vld_p2_d, vld_p2_q;
  logic vld_p3_d, vld_p3_q;
  logic en1, en2, en3;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [W-1:0]     nr_result;
  logic             nr_exception, nr_overflow, nr_underflow;

  always_comb begin
    en3      = !vld_p3_q || out_ready;
    en2      = !vld_p2_q || en3;
    en1      = !vld_p1_q || en2;
    vld_p1_d = en1 ? in_valid : vld_p1_q;
    vld_p2_d = en2 ? vld_p1_q : vld_p2_q;
    vld_p3_d = en3 ? vld_p2_q : vld_p3_q;
  end

  assign in_ready = en1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  // ---- S1: decode (subnormal inputs count as zero) ----
  always_comb begin
    a_exp = a_operand[W-2 -: EXP_W];
    b_exp = b_operand[W-2 -: EXP_W];
    s1_d  = s1_q;
    if (en1) begin
      s1_d.tag.sign = a_operand[W-1] ^ b_operand[W-1];
      s1_d.tag.exc  = (&a_exp) | (&b_exp);
      s1_d.tag.zero = (a_exp == '0) | (b_exp == '0);
      s1_d.esum     = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_S;
      s1_d.sig_a    = {1'b1, a_operand[MAN_W-1:0]};
      s1_d.sig_b    = {1'b1, b_operand[MAN_W-1:0]};
    end
  end

  // ---- S2: full significand product ----
  always_comb begin
    s2_d = s2_q;
    if (en2) begin
      s2_d.tag  = s1_q.tag;
      s2_d.esum = s1_q.esum;
      s2_d.prod = PW'(s1_q.sig_a) * PW'(s1_q.sig_b);
    end
  end

  // ---- S3: normalise, round, saturate, pack ----
  fp_mul_norm_round #(
    .EXP_W      (EXP_W),
    .MAN_W      (MAN_W),
    .ROUND_MODE (ROUND_MODE)
  ) u_norm_round (
    .sign      (s2_q.tag.sign),
    .exc       (s2_q.tag.exc),
    .zero      (s2_q.tag.zero),
    .esum      (s2_q.esum),
    .prod      (s2_q.prod),
    .result    (nr_result),
    .exception (nr_exception),
    .overflow  (nr_overflow),
    .underflow (nr_underflow)
  );

  always_comb begin
    s3_d = s3_q;
    if (en3) begin
      s3_d.result    = nr_result;
      s3_d.exception = nr_exception;
      s3_d.overflow  = nr_overflow;
      s3_d.underflow = nr_underflow;
    end
  end

  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
    s3_q <= s3_d;
  end

  // Payload is qualified by the stage-3 valid so idle and reset outputs read as zero.
  assign out_valid = vld_p3_q;
  assign result    = vld_p3_q ? s3_q.result : '0;
  assign exception = vld_p3_q & s3_q.exception;
  assign overflow  = vld_p3_q & s3_q.overflow;
  assign underflow = vld_p3_q & s3_q.underflow;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: truncating and round-to-nearest-even instances
// run in lockstep against a real-arithmetic reference model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a_op = '0;
  logic [31:0] b_op = '0;

  logic        in_ready, out_valid, exception_t, overflow_t, underflow_t;
  logic [31:0] result_t;
  logic        in_ready_r, out_valid_r, exception_r, overflow_r, underflow_r;
  logic [31:0] result_r;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .ROUND_MODE(0)) u_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_op), .b_operand(b_op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result_t), .exception(exception_t), .overflow(overflow_t), .underflow(underflow_t)
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .ROUND_MODE(1)) u_rne (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .a_operand(a_op), .b_operand(b_op), .out_valid(out_valid_r), .out_ready(out_ready),
    .result(result_r), .exception(exception_r), .overflow(overflow_r), .underflow(underflow_r)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt;
    logic [31:0] rr;
    logic [2:0]  ft;
    logic [2:0]  fr;
    bit          lat;
    int          tc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_xfer  = 0;

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  // Reference: exact product in double precision, then re-rounded to single with
  // DAZ inputs, flush-to-zero outputs and saturation to infinity. Returns {exc,ovf,unf,word}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input bit rne);
    logic        s;
    int          ea, eb, e;
    real         p;
    logic [63:0] d;
    logic [23:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {3'b100, s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0)     return {3'b000, s, 31'h0};
    p = $bitstoreal({a[31], 11'(ea + 896), a[22:0], 29'h0})
      * $bitstoreal({b[31], 11'(eb + 896), b[22:0], 29'h0});
    d = $realtobits(p);
    e = int'(d[62:52]) - 896;
    m = {1'b0, d[51:29]};
    if (rne && d[28] && ((|d[27:0]) || m[0])) m = m + 24'd1;
    if (m[23]) e = e + 1;
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, s, 31'h0};
    return {3'b000, s, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int          k;
    logic [7:0]  e;
    logic [22:0] m;
    k = int'($urandom_range(0, 19));
    if (k == 0)      e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else if (k <= 5) e = 8'($urandom_range(1, 20));
    else if (k <= 9) e = 8'($urandom_range(235, 254));
    else             e = 8'($urandom_range(60, 195));
    m = (k % 3 == 0) ? 23'h7FFFFF : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [34:0] et, input logic [34:0] er, input bit lat);
    int   waitc;
    int   tcv;
    exp_t e;
    waitc    = 0;
    a_op     = a;
    b_op     = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    tcv = cyc;
    @(posedge clk);
    e.a   = a;
    e.b   = b;
    e.rt  = et[31:0];
    e.ft  = et[34:32];
    e.rr  = er[31:0];
    e.fr  = er[34:32];
    e.lat = lat;
    e.tc  = tcv;
    sb.push_back(e);
    n_xfer++;
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation on every output transfer.
  initial begin : monitor
    exp_t        e;
    bit          held;
    logic [31:0] h_rt, h_rr;
    logic [2:0]  h_ft, h_fr;
    held = 0;
    h_rt = '0; h_rr = '0; h_ft = '0; h_fr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        chk("valid_lockstep", 32'(out_valid_r), 32'(out_valid));
        chk("ready_lockstep", 32'(in_ready_r), 32'(in_ready));
        if (held) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_result_trunc", result_t, h_rt);
          chk("hold_result_rne", result_r, h_rr);
          chk("hold_flags_trunc", 32'({exception_t, overflow_t, underflow_t}), 32'(h_ft));
          chk("hold_flags_rne", 32'({exception_r, overflow_r, underflow_r}), 32'(h_fr));
        end
        if (!out_valid) begin
          chk("idle_result", result_t, 32'd0);
          chk("idle_flags", 32'({exception_t, overflow_t, underflow_t}), 32'd0);
        end else if (out_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %h required no output", result_t);
          end else begin
            e = sb.pop_front();
            chk($sformatf("result_trunc a=%h b=%h", e.a, e.b), result_t, e.rt);
            chk($sformatf("result_rne a=%h b=%h", e.a, e.b), result_r, e.rr);
            chk($sformatf("flags_trunc a=%h b=%h", e.a, e.b),
                32'({exception_t, overflow_t, underflow_t}), 32'(e.ft));
            chk($sformatf("flags_rne a=%h b=%h", e.a, e.b),
                32'({exception_r, overflow_r, underflow_r}), 32'(e.fr));
            if (e.lat) chk("latency", 32'(cyc - e.tc), 32'd3);
          end
        end
        held = out_valid && !out_ready;
        h_rt = result_t;
        h_rr = result_r;
        h_ft = {exception_t, overflow_t, underflow_t};
        h_fr = {exception_r, overflow_r, underflow_r};
      end
    end
  end

  logic [31:0] da  [12] = '{32'h40000000, 32'h3FC00000, 32'h7F000000, 32'h00800000,
                            32'h7F800000, 32'h3FC00000, 32'h80000000, 32'h00000001,
                            32'h7FC00000, 32'h7F7FFFFF, 32'h00800000, 32'hC0000000};
  logic [31:0] db  [12] = '{32'h40400000, 32'h3FC00000, 32'h7F000000, 32'h00800000,
                            32'h00000000, 32'h3F800001, 32'h40000000, 32'h3F800000,
                            32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
  logic [31:0] drt [12] = '{32'h40C00000, 32'h40100000, 32'h7F800000, 32'h00000000,
                            32'h7F800000, 32'h3FC00001, 32'h80000000, 32'h00000000,
                            32'hFF800000, 32'h7F7FFFFF, 32'h00800000, 32'hC0800000};
  logic [31:0] drr [12] = '{32'h40C00000, 32'h40100000, 32'h7F800000, 32'h00000000,
                            32'h7F800000, 32'h3FC00002, 32'h80000000, 32'h00000000,
                            32'hFF800000, 32'h7F7FFFFF, 32'h00800000, 32'hC0800000};
  logic [2:0]  dfl [12] = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000,
                            3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};

  initial begin : stimulus
    int          base;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result_t, 32'd0);
    chk("reset_flags", 32'({exception_t, overflow_t, underflow_t}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++)
      issue(da[i], db[i], {dfl[i], drt[i]}, {dfl[i], drr[i]}, 1'b1);
    drain();

    // Backpressure: eight pairs offered while the sink stalls for six cycles.
    fork
      begin
        out_ready = 1'b0;
        base = n_xfer;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_transfers_while_stalled", 32'(n_xfer - base), 32'd3);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          chk("bp_no_gap", 32'(out_valid), 32'd1);
        end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          a = 32'h40000000 + (i << 20);
          b = 32'h3FC00000 + i;
          issue(a, b, model(a, b, 0), model(a, b, 1), 1'b0);
        end
      end
    join
    drain();

    // Random operands with random sink stalls and input gaps.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 150; i++) begin
          a = rand_op();
          b = rand_op();
          issue(a, b, model(a, b, 0), model(a, b, 1), 1'b0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with two pairs in flight.
    issue(32'h40400000, 32'h40400000, model(32'h40400000, 32'h40400000, 0),
          model(32'h40400000, 32'h40400000, 1), 1'b1);
    issue(32'h40800000, 32'h40800000, model(32'h40800000, 32'h40800000, 0),
          model(32'h40800000, 32'h40800000, 1), 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result_t, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    issue(32'h40000000, 32'hC0A00000, {3'b000, 32'hC1200000}, {3'b000, 32'hC1200000}, 1'b1);
    drain();
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
